mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store controller that drives the word-addressed data memory port: addr, din, mem_read, mem_write and dout.
- Accepts one CPU load/store request at a time, in RISC-V funct3 encoding.
- The memory only writes whole words, so byte and halfword stores run as read-modify-write.
- Extracts and sign- or zero-extends sub-word loads; rejects misaligned, out-of-range and invalid requests without touching memory.

Parameters:
- MEM_DEPTH, 16384, words in the attached memory; valid byte addresses are 0 to MEM_DEPTH*4-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SB uses [7:0], SH uses [15:0].
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request rejected, qualified by resp_valid.
- mem_addr  out  32  byte address to memory, always word-aligned ({req_addr[31:2],2'b00}).
- mem_din  out  32  write data to memory.
- mem_read  out  1  read enable.
- mem_write  out  1  write enable; memory commits at the posedge ending the cycle.
- mem_dout  in  32  asynchronous read data from memory.

Behaviour:
- Reset values: req_ready=1 after the reset cycle; resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_din=0; state=IDLE.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: on req_valid&&req_ready, latch write, funct3, addr and wdata, then decode.
  - Error → RESP with err=1. Error means any of: invalid funct3 for the direction; misaligned (LH/LHU/SH with addr[0]≠0, LW/SW with addr[1:0]≠0); addr ≥ MEM_DEPTH*4.
  - Load → LOAD.
  - SW → STORE.
  - SB/SH → RMW_RD.
- LOAD: mem_read=1. Register the formatted mem_dout: lane selected by addr[1:0] (byte) or addr[1] (half), sign- or zero-extended per funct3. Then → RESP.
- STORE: mem_write=1, mem_din=wdata, then → RESP.
- RMW_RD: mem_read=1, capture mem_dout into the merge register, then → RMW_WR.
- RMW_WR: mem_write=1. mem_din is the captured word with the selected byte/half lane replaced by wdata[7:0]/[15:0]. Then → RESP.
- RESP: resp_valid=1 for exactly one cycle with latched rdata and err, then → IDLE.
- Latency, accept cycle to resp_valid:
  - load or SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- mem_read and mem_write are never high in the same cycle and are never high in IDLE or RESP.
- Error requests generate no memory access.
- mem_write is high exactly one cycle per store.
- Requests presented while req_ready=0 are ignored; the requester holds them.
- Reset mid-operation (any state): the next state is IDLE and no mem_write occurs in the cycle where reset is sampled high. The pending request is dropped and no resp_valid is produced.
- Back-to-back: a new request is accepted in the cycle after RESP. A store's data is visible to a following load.

Optional Feature:
- MAU_STATS_EN defined:
  - adds outputs stat_loads[31:0], stat_stores[31:0] and stat_errs[31:0];
  - each increments on the RESP cycle of a successful load, a successful store, or an error respectively;
  - all three clear on reset and wrap modulo 2^32.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- mau_pkg holds:
  - state enum;
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - localparam for the valid-funct3 sets.
- Sub-module mau_align (combinational) holds load lane extract/extend and store lane merge. It is shared by LOAD and RMW_WR.

Test Plan:
- Preload word 0x10 = 0x808182F3.
  - LB 0x13 → resp_rdata=0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF8081.
  - LHU 0x10 → 0x000082F3.
  - Each load's resp_valid occurs 2 cycles after accept.
- SB wdata=0x000000AB at 0x11 → one mem_read cycle, then one mem_write cycle with mem_din=0x8081ABF3 at mem_addr=0x10; resp_valid 3 cycles after accept; a following LW 0x10 returns 0x8081ABF3.
- LW 0x12, SH 0x13 and funct3=011 → resp_err=1 one cycle after accept; mem_read and mem_write stay 0 throughout.
- LW at 0x10000 with MEM_DEPTH=16384 → resp_err=1 and no memory access.
- SW 0xDEADBEEF to 0x20, then LW 0x20 back-to-back → 0xDEADBEEF; req_ready is low from accept through RESP.
- SH accepted, then reset asserted during RMW_RD → no mem_write cycle and no resp_valid; req_ready=1 after reset.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and constants for the load/store controller: FSM states,
// RISC-V funct3 encodings and the legal funct3 sets for each direction.
package mau_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bit n set means funct3 value n is legal for that direction.
  localparam logic [7:0] LOAD_F3_SET  = 8'b0011_0111;
  localparam logic [7:0] STORE_F3_SET = 8'b0000_0111;

  function automatic logic f3_valid(input logic write, input logic [2:0] f3);
    return write ? STORE_F3_SET[f3] : LOAD_F3_SET[f3];
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return (lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_align.sv
// Combinational lane logic: sub-word load extract/extend and store lane merge.
module mau_align
  import mau_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] load_word,
  input  logic [31:0] store_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = load_word[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? load_word[31:16] : load_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    merge_data = store_word;
    if (funct3 == F3_B) begin
      merge_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == F3_H) begin
      if (byte_off[1]) merge_data[31:16] = wdata[15:0];
      else             merge_data[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller for a word-wide memory; sub-word stores use read-modify-write.
// Optional MAU_STATS_EN adds load/store/error response counters.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
`ifdef MAU_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) * 33'd4;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;
  logic        err_q, err_d;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  mau_align u_align (
    .funct3     (funct3_q),
    .byte_off   (addr_q[1:0]),
    .load_word  (mem_dout),
    .store_word (merge_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign req_err = !f3_valid(req_write, req_funct3)
                || f3_misaligned(req_funct3, req_addr[1:0])
                || ({1'b0, req_addr} >= ADDR_LIMIT);

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    merge_d  = merge_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = req_err;
          if (req_err)                  state_d = RESP;
          else if (!req_write)          state_d = LOAD;
          else if (req_funct3 == F3_W)  state_d = STORE;
          else                          state_d = RMW_RD;
        end
      end
      LOAD: begin
        rdata_d = load_data;
        state_d = RESP;
      end
      STORE:   state_d = RESP;
      RMW_RD: begin
        merge_d = mem_dout;
        state_d = RMW_WR;
      end
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merge_q  <= merge_d;
      err_q    <= err_d;
    end
  end

  // Strobes are masked by reset so an aborted store never commits.
  always_comb begin
    req_ready  = (state_q == IDLE);
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_read   = !reset && ((state_q == LOAD) || (state_q == RMW_RD));
    mem_write  = !reset && ((state_q == STORE) || (state_q == RMW_WR));
    mem_din    = 32'h0;
    if (state_q == STORE)       mem_din = wdata_q;
    else if (state_q == RMW_WR) mem_din = merge_data;
    resp_valid = !reset && (state_q == RESP);
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    resp_err   = resp_valid && err_q;
  end

`ifdef MAU_STATS_EN
  logic [31:0] loads_q, loads_d;
  logic [31:0] stores_q, stores_d;
  logic [31:0] errs_q, errs_d;

  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    errs_d   = errs_q;
    if (state_q == RESP) begin
      if (err_q)        errs_d   = errs_q + 32'd1;
      else if (write_q) stores_d = stores_q + 32'd1;
      else              loads_d  = loads_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loads_q  <= 32'h0;
      stores_q <= 32'h0;
      errs_q   <= 32'h0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      errs_q   <= errs_d;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit against a byte-level memory model.
module tb_mem_access_unit;

  localparam int MEM_DEPTH = 16384;
  localparam int NBYTES    = MEM_DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;
`ifdef MAU_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
  int          exp_loads = 0, exp_stores = 0, exp_errs = 0;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
`ifdef MAU_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  // Attached word memory (the environment), separate from the reference model.
  logic [31:0] tb_mem [0:MEM_DEPTH-1];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr[15:2]] <= mem_din;
  assign mem_dout = tb_mem[mem_addr[15:2]];

  // Reference model: flat little-endian byte memory.
  logic [7:0] ref_mem [0:NBYTES-1];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          reads;
    int          writes;
    logic [31:0] waddr;
    logic [31:0] wword;
    int          acc_cyc;
    logic        is_write;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output exp_t e);
    int          sz;
    logic        ok;
    logic [31:0] v;
    logic [31:0] wa;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((a % sz) != 0) ok = 1'b0;
    if (a >= 32'(NBYTES)) ok = 1'b0;
    e = '{err: 1'b0, rdata: 32'h0, lat: 1, reads: 0, writes: 0,
          waddr: 32'h0, wword: 32'h0, acc_cyc: 0, is_write: w};
    if (!ok) begin
      e.err = 1'b1;
    end else if (!w) begin
      v = 32'h0;
      for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
      if (!f3[2] && sz == 1) v = 32'($signed(v[7:0]));
      if (!f3[2] && sz == 2) v = 32'($signed(v[15:0]));
      e.rdata = v;
      e.lat   = 2;
      e.reads = 1;
    end else begin
      for (int k = 0; k < sz; k++) ref_mem[a + k] = d[8*k +: 8];
      wa       = a & ~32'h3;
      e.waddr  = wa;
      e.wword  = {ref_mem[wa + 3], ref_mem[wa + 2], ref_mem[wa + 1], ref_mem[wa]};
      e.writes = 1;
      e.reads  = (sz < 4) ? 1 : 0;
      e.lat    = (sz < 4) ? 3 : 2;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit track);
    int   waitc;
    exp_t e;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    if (track) begin
      model(w, f3, a, d, e);
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(negedge clk);
    req_valid  = 1'b0;
    req_wdata  = $urandom;
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each response.
  int rd_cnt = 0;
  int wr_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_cnt = 0;
        wr_cnt = 0;
`ifdef MAU_STATS_EN
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
`endif
      end else begin
        if (mem_read && mem_write) check32("rd_wr_overlap", 32'(mem_write), 32'h0);
        if (mem_read) rd_cnt++;
        if (mem_write) begin
          wr_cnt++;
          if (sb.size() == 0) check32("stray_write", 32'(mem_write), 32'h0);
          else begin
            check32("wr_addr", mem_addr, sb[0].waddr);
            check32("wr_data", mem_din, sb[0].wword);
          end
        end
        if (resp_valid) begin
          if (sb.size() == 0) check32("stray_resp", 32'(resp_valid), 32'h0);
          else begin
            e = sb.pop_front();
            check32("resp_err", 32'(resp_err), 32'(e.err));
            check32("resp_rdata", resp_rdata, e.rdata);
            check32("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            check32("read_cycles", 32'(rd_cnt), 32'(e.reads));
            check32("write_cycles", 32'(wr_cnt), 32'(e.writes));
            check32("ready_in_resp", 32'(req_ready), 32'h0);
`ifdef MAU_STATS_EN
            if (e.err) exp_errs++;
            else if (e.is_write) exp_stores++;
            else exp_loads++;
`endif
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] a;
    int          waitc;

    for (int i = 0; i < MEM_DEPTH; i++) begin
      w = (i == 4) ? 32'h808182F3 : $urandom;
      tb_mem[i] = w;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check32("rst_req_ready", 32'(req_ready), 32'h1);
    check32("rst_resp_valid", 32'(resp_valid), 32'h0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_resp_err", 32'(resp_err), 32'h0);
    check32("rst_mem_read", 32'(mem_read), 32'h0);
    check32("rst_mem_write", 32'(mem_write), 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_din", mem_din, 32'h0);

    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1);
    issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b1);
    issue(1'b1, 3'b000, 32'h11, 32'h000000AB, 1'b1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h12, 32'h0, 1'b1);
    issue(1'b1, 3'b001, 32'h13, 32'h1234, 1'b1);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h10000, 32'h0, 1'b1);
    issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);

    // Abort an SH during its read phase; memory must stay untouched.
    issue(1'b1, 3'b001, 32'h32, 32'h5A5A, 1'b0);
    check32("abort_in_rmw_rd", 32'(mem_read), 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check32("ready_after_abort", 32'(req_ready), 32'h1);
    repeat (4) @(negedge clk);
    issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      rw = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = rw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(NBYTES - 8, NBYTES + 8));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      issue(rw, f3, a, $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    waitc = 0;
    while (sb.size() != 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check32("drain", 32'(sb.size()), 32'h0);
`ifdef MAU_STATS_EN
    @(negedge clk);
    check32("stat_loads", stat_loads, 32'(exp_loads));
    check32("stat_stores", stat_stores, 32'(exp_stores));
    check32("stat_errs", stat_errs, 32'(exp_errs));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
